// File: rtl/fetch_queue_pkg.sv
// Shared fetch-bundle definitions used by fetch, the fetch queue and decode.
package fetch_queue_pkg;

    localparam int FETCH_WIDTH = 2;

    localparam int INST_ADDR_WIDTH = 32;

    localparam int FETCH_Q_DEPTH = 4;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0][31:0]  inst;
        logic [INST_ADDR_WIDTH-1:0]    pc;
        logic [INST_ADDR_WIDTH-1:0]    pc_plus_4;
    } fq_bundle_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetch bundles between fetch and decode, with a full-driven
// fetch stall, flush support and a sticky overflow flag.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_Q_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [FETCH_WIDTH-1:0][31:0]      in_inst,
    input  logic [INST_ADDR_WIDTH-1:0]        in_pc,
    input  logic [INST_ADDR_WIDTH-1:0]        in_pc_plus_4,
    input  logic                              flush,
    output logic                              fetch_stall,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [FETCH_WIDTH-1:0][31:0]      out_inst,
    output logic [INST_ADDR_WIDTH-1:0]        out_pc,
    output logic [INST_ADDR_WIDTH-1:0]        out_pc_plus_4,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    fq_bundle_t        mem [DEPTH];
    fq_bundle_t        bundle_in;
    fq_bundle_t        head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              push;
    logic              pop;

    assign bundle_in = '{inst: in_inst, pc: in_pc, pc_plus_4: in_pc_plus_4};

    // Status depends only on registered count, so fetch_stall has no path from in_valid.
    assign full        = (count == FULL_COUNT);
    assign out_valid   = (count != '0);
    assign fetch_stall = full;

    assign push = in_valid  && !full && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign head          = mem[rd_ptr];
    assign out_inst      = head.inst;
    assign out_pc        = head.pc;
    assign out_pc_plus_4 = head.pc_plus_4;

    // NOTE: state registers use non-blocking assignments so every read in this
    // block sees the pre-edge value, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
            // NOTE: storage is cleared on reset because the head entry is visible
            // on out_* even while empty; this makes it a flop array, not a RAM.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bundle_in;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (in_valid && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          in_valid;
    logic [FETCH_WIDTH-1:0][31:0]  in_inst;
    logic [INST_ADDR_WIDTH-1:0]    in_pc;
    logic [INST_ADDR_WIDTH-1:0]    in_pc_plus_4;
    logic                          flush;
    logic                          fetch_stall;
    logic                          out_valid;
    logic                          out_ready;
    logic [FETCH_WIDTH-1:0][31:0]  out_inst;
    logic [INST_ADDR_WIDTH-1:0]    out_pc;
    logic [INST_ADDR_WIDTH-1:0]    out_pc_plus_4;
    logic [CNT_W-1:0]              count;
    logic                          overflow_err;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .in_pc_plus_4  (in_pc_plus_4),
        .flush         (flush),
        .fetch_stall   (fetch_stall),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_pc_plus_4 (out_pc_plus_4),
        .count         (count),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    fq_bundle_t exp_q[$];
    logic       exp_ovf  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head bundle must match the oldest expected bundle.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                check("pop_with_empty_model", 64'(out_valid), 64'(0));
            end else begin
                fq_bundle_t e;
                e = exp_q.pop_front();
                check("pop_pc", 64'(out_pc), 64'(e.pc));
                check("pop_pc_plus_4", 64'(out_pc_plus_4), 64'(e.pc_plus_4));
                for (int s = 0; s < FETCH_WIDTH; s++) begin
                    check("pop_inst", 64'(out_inst[s]), 64'(e.inst[s]));
                end
            end
        end
    end

    // One cycle: check post-edge state against the model, then drive this cycle's inputs.
    task automatic step(input logic iv, input logic [31:0] pc, input logic fl, input logic rdy);
        fq_bundle_t b;
        int occ;
        @(posedge clk);
        #1;
        occ = exp_q.size();
        check("count", 64'(count), 64'(occ));
        check("out_valid", 64'(out_valid), 64'(occ != 0));
        check("fetch_stall", 64'(fetch_stall), 64'(occ == DEPTH));
        check("overflow_err", 64'(overflow_err), 64'(exp_ovf));
        if (occ != 0) begin
            check("head_pc", 64'(out_pc), 64'(exp_q[0].pc));
        end
        b.pc        = pc;
        b.pc_plus_4 = pc + 32'd4;
        b.inst[0]   = pc ^ 32'h1357_0013;
        for (int s = 1; s < FETCH_WIDTH; s++) begin
            b.inst[s] = $urandom;
        end
        in_valid     = iv;
        in_pc        = b.pc;
        in_pc_plus_4 = b.pc_plus_4;
        in_inst      = b.inst;
        flush        = fl;
        out_ready    = rdy;
        if (fl) begin
            exp_q.delete();
        end else if (iv) begin
            if (occ < DEPTH) exp_q.push_back(b);
            else             exp_ovf = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_pc", 64'(out_pc), 64'(0));
        check("rst_out_pc_plus_4", 64'(out_pc_plus_4), 64'(0));
        check("rst_out_inst", 64'(out_inst), 64'(0));
        check("rst_overflow_err", 64'(overflow_err), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_inst      = '0;
        in_pc        = '0;
        in_pc_plus_4 = '0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Fill to full without draining, then drain in order.
        for (int i = 0; i < 4; i++) step(1, 32'(i * 8), 0, 0);
        step(0, 0, 0, 0);
        check("full_head_pc", 64'(out_pc), 64'h00);
        check("full_stall", 64'(fetch_stall), 64'(1));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Sustained push and pop from empty; pointers wrap several times.
        pc = 32'h100;
        for (int i = 0; i < 10; i++) begin
            step(1, pc, 0, 1);
            pc += 32'd8;
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Flush with a concurrent bundle: nothing survives.
        for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(i * 8), 0, 0);
        step(1, 32'h40, 1, 0);
        step(0, 0, 0, 1);
        check("post_flush_count", 64'(count), 64'(0));
        step(0, 0, 0, 0);

        // Overflow is sticky through flush; reset clears it.
        for (int i = 0; i < 4; i++) step(1, 32'h300 + 32'(i * 8), 0, 0);
        step(1, 32'h80, 0, 0);
        step(0, 0, 0, 0);
        check("ovf_set", 64'(overflow_err), 64'(1));
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("ovf_after_flush", 64'(overflow_err), 64'(1));
        do_reset();
        step(0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 70) ? 1'b1 : 1'b0,
                 32'($urandom) & 32'hFFFF_FFF8,
                 ($urandom_range(99) < 4) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < 55) ? 1'b1 : 1'b0);
        end
        step(0, 0, 0, 0);

        // Mid-stream reset clears storage as well as state.
        for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(i * 8), 0, 0);
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the instruction fetch unit and the decode/rename stage. Each cycle it accepts one fetch bundle (FETCH_WIDTH instruction words plus the bundle PC and PC+4) and presents the oldest bundle to decode under a valid/ready handshake. It generates the fetch-stall signal that freezes the PC when full, and it empties itself on a pipeline flush.

## Interface
- FETCH_WIDTH, `FETCH_WIDTH, instruction words per bundle
- INST_ADDR_WIDTH, `INST_ADDR_WIDTH, PC width
- DEPTH, 4, bundle entries; power of two, ≥2
---
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch bundle present (driven by fetch new_valid_inst)
- in_inst  in  [31:0] x FETCH_WIDTH  fetched instruction words, slot 0 oldest
- in_pc  in  INST_ADDR_WIDTH  PC of slot 0
- in_pc_plus_4  in  INST_ADDR_WIDTH  in_pc+4
- flush  in  1  discard all queued and incoming bundles
- fetch_stall  out  1  high when queue full; drives fetch stall
- out_valid  out  1  head bundle available
- out_ready  in  1  decode accepts head bundle
- out_inst  out  [31:0] x FETCH_WIDTH  head instruction words
- out_pc  out  INST_ADDR_WIDTH  head PC
- out_pc_plus_4  out  INST_ADDR_WIDTH  head PC+4
- count  out  $clog2(DEPTH+1)  occupied entries
- overflow_err  out  1  sticky: push attempted while full

## Operation
- Circular buffer of DEPTH bundle entries; wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap) and count.
- push = in_valid & (count != DEPTH) & ~flush. pop = out_valid & out_ready & ~flush.
- Push writes the bundle at wr_ptr and increments wr_ptr. Pop increments rd_ptr.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop on a full queue is impossible: fetch_stall blocks fetch. An in_valid arriving while full is dropped and sets overflow_err.
- Simultaneous push and pop on an empty queue: the push is stored and the pop does not occur (out_valid was 0).
- flush (priority over push/pop): pointers and count go to 0 next cycle. The in-cycle bundle is dropped. overflow_err is kept.
- Priority order: reset > flush > push/pop.
- NOP bundles produced by fetch on a redirect are queued like any other bundle. No opcode inspection.
- out_valid = (count != 0). out_* read combinationally from the entry at rd_ptr.
- fetch_stall = (count == DEPTH). It depends only on registered state, so there is no combinational path from in_valid.

## Timing
- Reset values: count 0, pointers 0, out_valid 0, fetch_stall 0, overflow_err 0. All storage entries are zeroed, so out_inst, out_pc and out_pc_plus_4 are 0.
- Latency: a bundle pushed at edge N appears on out_* with out_valid=1 after edge N; no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained.
- fetch_stall rises in the cycle after the push that fills the queue. It falls in the cycle after the first pop from full.
- flush at edge N: out_valid=0 and fetch_stall=0 after edge N. Decode must not consume out_* in the flush cycle.
- reset mid-stream has the same effect as flush, and additionally clears overflow_err and storage.

## Structure
- The shared package holds fq_bundle_t, a packed struct {inst[FETCH_WIDTH], pc, pc_plus_4} used by fetch, this block and decode. DEPTH default also goes in the package as FETCH_Q_DEPTH.
- Single module; no sub-module. Storage is an array of fq_bundle_t.

## Test plan
Parameters: FETCH_WIDTH=2, DEPTH=4, INST_ADDR_WIDTH=32.
- Reset, then idle -> out_valid=0, fetch_stall=0, count=0, out_pc=0.
- Push pc=0x00,0x08,0x10,0x18 on 4 consecutive cycles with out_ready=0 -> count=4 and fetch_stall=1 after 4th edge. out_pc=0x00, out_inst matches first bundle.
- From full, out_ready=1 with in_valid=0 for 4 cycles -> out_pc sequence 0x00,0x08,0x10,0x18, count 3..0, fetch_stall drops after the first pop.
- Continuous push/pop for 10 cycles from empty, pc stepping by 8 -> count stays 1, in-order delivery, and pointers wrap past 3 without loss.
- Queue holds 3 bundles; assert flush with in_valid=1, pc=0x40 -> next cycle count=0, out_valid=0. The 0x40 bundle never appears.
- With count=4, force in_valid=1 (pc=0x80) -> bundle dropped, overflow_err=1 and it stays high through a flush; reset clears it.
